// File: rtl/rob_complete_arb.sv
// ROB completion arbiter: one holding buffer per functional unit,
// round-robin grant to the ROB/CDB, with branch-rollback squash.
module rob_complete_arb #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int PR_IDX_W  = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]  req_rob_idx,
  input  logic [NUM_REQ*PR_IDX_W-1:0]   req_T_idx,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ROB_IDX_W-1:0]          rob_head_idx,
  input  logic                          rollback_en,
  input  logic [ROB_IDX_W-1:0]          rollback_idx,
  output logic                          complete_en,
  output logic [ROB_IDX_W-1:0]          complete_ROB_idx,
  output logic [PR_IDX_W-1:0]           complete_T_idx,
  output logic [NUM_REQ-1:0]            grant
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   buf_valid_q, buf_valid_d;
  logic [ROB_IDX_W-1:0] buf_rob_q [NUM_REQ];
  logic [ROB_IDX_W-1:0] buf_rob_d [NUM_REQ];
  logic [PR_IDX_W-1:0]  buf_t_q [NUM_REQ];
  logic [PR_IDX_W-1:0]  buf_t_d [NUM_REQ];
  logic [RR_W-1:0]      rr_q, rr_d;

  logic [ROB_IDX_W-1:0] in_rob [NUM_REQ];
  logic [PR_IDX_W-1:0]  in_t [NUM_REQ];
  logic [NUM_REQ-1:0]   squash;
  logic [NUM_REQ-1:0]   in_drop;
  logic [NUM_REQ-1:0]   eligible;
  logic [RR_W-1:0]      grant_idx;
  logic                 any_elig;
  logic                 dup_rob;

  // Ages are distances from the ROB head, so wrap-around compares cleanly.
  function automatic logic younger(
    input logic [ROB_IDX_W-1:0] x,
    input logic [ROB_IDX_W-1:0] b,
    input logic [ROB_IDX_W-1:0] h
  );
    logic [ROB_IDX_W-1:0] ax;
    logic [ROB_IDX_W-1:0] ab;
    ax = x - h;
    ab = b - h;
    return ax > ab;
  endfunction

  function automatic logic [RR_W-1:0] wrap_add(
    input logic [RR_W-1:0] a,
    input int              k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_W'(s);
  endfunction

  always_comb begin
    squash  = '0;
    in_drop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_rob[i]  = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      in_t[i]    = req_T_idx[i*PR_IDX_W +: PR_IDX_W];
      squash[i]  = rollback_en & buf_valid_q[i] &
                   younger(buf_rob_q[i], rollback_idx, rob_head_idx);
      in_drop[i] = rollback_en &
                   younger(in_rob[i], rollback_idx, rob_head_idx);
    end
  end

  assign eligible = buf_valid_q & ~squash;

  always_comb begin
    grant_idx = '0;
    any_elig  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_elig && eligible[wrap_add(rr_q, k)]) begin
        any_elig  = 1'b1;
        grant_idx = wrap_add(rr_q, k);
      end
    end
  end

  always_comb begin
    complete_en      = en & any_elig;
    grant            = '0;
    complete_ROB_idx = '0;
    complete_T_idx   = '0;
    if (complete_en) begin
      grant            = NUM_REQ'(1) << grant_idx;
      complete_ROB_idx = buf_rob_q[grant_idx];
      complete_T_idx   = buf_t_q[grant_idx];
    end
    req_ready = en ? (~buf_valid_q | grant) : '0;
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rob_d   = buf_rob_q;
    buf_t_d     = buf_t_q;
    rr_d        = rr_q;
    if (en) begin
      if (complete_en) rr_d = wrap_add(grant_idx, 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] | squash[i]) buf_valid_d[i] = 1'b0;
        // Freed this cycle by a grant: reload at the same edge.
        if (req_valid[i] & req_ready[i] & ~in_drop[i]) begin
          buf_valid_d[i] = 1'b1;
          buf_rob_d[i]   = in_rob[i];
          buf_t_d[i]     = in_t[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= '0;
      rr_q        <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_rob_q[i] <= '0;
        buf_t_q[i]   <= '0;
      end
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_q        <= rr_d;
      buf_rob_q   <= buf_rob_d;
      buf_t_q     <= buf_t_d;
    end
  end

  always_comb begin
    dup_rob = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (buf_valid_q[i] && buf_valid_q[j] &&
            buf_rob_q[i] == buf_rob_q[j])
          dup_rob = 1'b1;
      end
    end
  end

  // Requesters must never hold the same ROB entry twice.
  dup_rob_a: assert property (
    @(posedge clock) disable iff (reset) !dup_rob
  );

endmodule

// File: tb/tb_rob_complete_arb.sv
// Randomized + directed bench for rob_complete_arb against
// an array-based behavioural model of the holding buffers.
module tb_rob_complete_arb;

  logic        clock;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [19:0] req_rob_idx;
  logic [23:0] req_T_idx;
  logic [3:0]  req_ready;
  logic [4:0]  rob_head_idx;
  logic        rollback_en;
  logic [4:0]  rollback_idx;
  logic        complete_en;
  logic [4:0]  complete_ROB_idx;
  logic [5:0]  complete_T_idx;
  logic [3:0]  grant;

  rob_complete_arb #(
    .NUM_REQ(4),
    .ROB_IDX_W(5),
    .PR_IDX_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .req_valid(req_valid),
    .req_rob_idx(req_rob_idx),
    .req_T_idx(req_T_idx),
    .req_ready(req_ready),
    .rob_head_idx(rob_head_idx),
    .rollback_en(rollback_en),
    .rollback_idx(rollback_idx),
    .complete_en(complete_en),
    .complete_ROB_idx(complete_ROB_idx),
    .complete_T_idx(complete_T_idx),
    .grant(grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  bit mv [4];
  int mr [4];
  int mt [4];
  int mrr;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int age(input int x);
    return (x - int'(rob_head_idx) + 32) % 32;
  endfunction

  function automatic bit younger(input int x, input int b);
    return age(x) > age(b);
  endfunction

  task automatic set_req(input int i, input int r, input int t);
    req_rob_idx[i*5 +: 5] = 5'(r);
    req_T_idx[i*6 +: 6]   = 6'(t);
  endtask

  task automatic step();
    int g;
    int i;
    int er;
    int et;
    int ridx;
    int rb;
    bit ce;
    logic [3:0] eg;
    logic [3:0] rdy;
    #1;
    rb = int'(rollback_idx);
    g  = -1;
    for (int k = 0; k < 4; k++) begin
      i = (mrr + k) % 4;
      if (g < 0 && mv[i] && !(rollback_en && younger(mr[i], rb)))
        g = i;
    end
    ce = en && (g >= 0);
    eg = 4'b0;
    er = 0;
    et = 0;
    if (ce) begin
      eg[g] = 1'b1;
      er    = mr[g];
      et    = mt[g];
    end
    for (int j = 0; j < 4; j++)
      rdy[j] = en && (!mv[j] || eg[j]);
    chk("complete_en", 32'(complete_en), 32'(ce));
    chk("grant", 32'(grant), 32'(eg));
    chk("rob_idx", 32'(complete_ROB_idx), er);
    chk("T_idx", 32'(complete_T_idx), et);
    chk("req_ready", 32'(req_ready), 32'(rdy));
    @(posedge clock);
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        mv[j] = 1'b0;
        mr[j] = 0;
        mt[j] = 0;
      end
      mrr = 0;
    end else if (en) begin
      for (int j = 0; j < 4; j++) begin
        if (eg[j]) mv[j] = 1'b0;
        if (rollback_en && mv[j] && younger(mr[j], rb)) mv[j] = 1'b0;
        ridx = int'(req_rob_idx[j*5 +: 5]);
        if (req_valid[j] && rdy[j] && !(rollback_en && younger(ridx, rb))) begin
          mv[j] = 1'b1;
          mr[j] = ridx;
          mt[j] = int'(req_T_idx[j*6 +: 6]);
        end
      end
      if (ce) mrr = (g + 1) % 4;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    en           = 1'b1;
    req_valid    = 4'b0;
    rollback_en  = 1'b0;
    rollback_idx = 5'd0;
    rob_head_idx = 5'd0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int r;
    bit clash;
    for (int j = 0; j < 4; j++) begin
      mv[j] = 1'b0;
      mr[j] = 0;
      mt[j] = 0;
    end
    mrr          = 0;
    reset        = 1'b1;
    en           = 1'b1;
    req_valid    = 4'b0;
    req_rob_idx  = '0;
    req_T_idx    = '0;
    rob_head_idx = 5'd0;
    rollback_en  = 1'b0;
    rollback_idx = 5'd0;
    @(posedge clock);
    @(negedge clock);
    do_reset();

    // single request
    set_req(0, 3, 17);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0;
    #1;
    chk("s_en", 32'(complete_en), 1);
    chk("s_rob", 32'(complete_ROB_idx), 3);
    chk("s_t", 32'(complete_T_idx), 17);
    chk("s_grant", 32'(grant), 1);
    step();

    // full contention
    do_reset();
    for (int j = 0; j < 4; j++) set_req(j, 4 + j, 10 + j);
    req_valid = 4'hf;
    step();
    req_valid = 4'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("c_grant", 32'(grant), 32'(1) << k);
      step();
    end
    #1;
    chk("c_idle", 32'(complete_en), 0);
    step();

    // back-to-back on requester 2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_req(2, k, 20 + k);
      req_valid = 4'b0100;
      #1;
      if (k > 0) chk("b_en", 32'(complete_en), 1);
      chk("b_rdy", 32'(req_ready[2]), 1);
      step();
    end
    req_valid = 4'b0;
    step();

    // rollback across the index wrap
    do_reset();
    rob_head_idx = 5'd30;
    set_req(0, 31, 1);
    set_req(1, 1, 2);
    set_req(2, 2, 3);
    set_req(3, 0, 4);
    req_valid = 4'hf;
    step();
    req_valid    = 4'b0;
    rollback_en  = 1'b1;
    rollback_idx = 5'd1;
    #1;
    chk("r_grant0", 32'(grant), 1);
    chk("r_rob0", 32'(complete_ROB_idx), 31);
    step();
    rollback_en = 1'b0;
    #1;
    chk("r_grant1", 32'(grant), 2);
    step();
    #1;
    chk("r_grant3", 32'(grant), 8);
    step();
    #1;
    chk("r_idle", 32'(complete_en), 0);
    step();

    // enable low freezes state and pointer
    do_reset();
    set_req(0, 3, 1);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0;
    step();
    set_req(0, 8, 2);
    set_req(2, 9, 3);
    req_valid = 4'b0101;
    step();
    req_valid = 4'b0;
    en        = 1'b0;
    repeat (3) begin
      #1;
      chk("e_en", 32'(complete_en), 0);
      chk("e_rdy", 32'(req_ready), 0);
      step();
    end
    en = 1'b1;
    #1;
    chk("e_grant", 32'(grant), 4);
    step();
    step();

    // reset wins over rollback
    do_reset();
    for (int j = 0; j < 4; j++) set_req(j, 10 + j, 30 + j);
    req_valid = 4'hf;
    step();
    req_valid    = 4'b0;
    rollback_en  = 1'b1;
    rollback_idx = 5'd10;
    reset        = 1'b1;
    step();
    reset       = 1'b0;
    rollback_en = 1'b0;
    #1;
    chk("x_en", 32'(complete_en), 0);
    chk("x_rdy", 32'(req_ready), 15);
    step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      en           = ($urandom_range(0, 9) != 0);
      reset        = ($urandom_range(0, 99) == 0);
      rollback_en  = ($urandom_range(0, 4) == 0);
      rollback_idx = 5'($urandom_range(0, 31));
      rob_head_idx = 5'($urandom_range(0, 31));
      req_valid    = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) begin
        do begin
          r     = $urandom_range(0, 31);
          clash = 1'b0;
          for (int m = 0; m < 4; m++)
            if (mv[m] && mr[m] == r) clash = 1'b1;
          for (int m = 0; m < j; m++)
            if (int'(req_rob_idx[m*5 +: 5]) == r) clash = 1'b1;
        end while (clash);
        set_req(j, r, $urandom_range(0, 63));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rob_complete_arb.md
ROB_COMPLETE_ARB -- requirements
Module: rob_complete_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit completion requesters (2..8).
REQ-002 Parameter ROB_IDX_W, default 5, ROB index width; ROB depth is 2^ROB_IDX_W.
REQ-003 Parameter PR_IDX_W, default 6, physical-register index width.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  global enable; low freezes all state.
REQ-007 req_valid  input  NUM_REQ  per-requester completion request.
REQ-008 req_rob_idx  input  NUM_REQ*ROB_IDX_W  ROB index per requester; slice i at [i*ROB_IDX_W +: ROB_IDX_W].
REQ-009 req_T_idx  input  NUM_REQ*PR_IDX_W  destination physical register per requester, same slicing.
REQ-010 req_ready  output  NUM_REQ  requester i may present a new request this cycle.
REQ-011 rob_head_idx  input  ROB_IDX_W  current ROB head, age reference.
REQ-012 rollback_en  input  1  branch mispredict recovery this cycle.
REQ-013 rollback_idx  input  ROB_IDX_W  ROB index of the mispredicted branch.
REQ-014 complete_en  output  1  one completion presented to ROB/CDB this cycle.
REQ-015 complete_ROB_idx  output  ROB_IDX_W  ROB index being completed.
REQ-016 complete_T_idx  output  PR_IDX_W  physical register being broadcast.
REQ-017 grant  output  NUM_REQ  one-hot identity of the granted holding buffer (zero when complete_en low).

Function
REQ-018 Each requester owns one holding buffer {valid, rob_idx, T_idx}; accept occurs on a rising edge where en, req_valid[i] and req_ready[i] are all high.
REQ-019 req_ready[i] = en & (!buf_valid[i] | grant[i]); a buffer granted in cycle t accepts a new request at the same edge (back-to-back throughput, one per requester per cycle).
REQ-020 Age: age(x) = (x - rob_head_idx) mod 2^ROB_IDX_W; entry x is younger than branch b iff age(x) > age(b); equal index is not younger.
REQ-021 Eligible[i] = buf_valid[i] & !(rollback_en & younger(buf_rob_idx[i], rollback_idx)).
REQ-022 Round-robin pointer rr (log2 NUM_REQ bits): grant goes to the first eligible buffer searching rr, rr+1, ... modulo NUM_REQ.
REQ-023 complete_en = en & (any eligible); complete_ROB_idx/complete_T_idx are the granted buffer's fields, combinational from buffer state (zero when complete_en low).
REQ-024 Latency: request accepted at edge t -> earliest complete_en in cycle following edge t (one cycle); never same-cycle pass-through.
REQ-025 On a grant to buffer g with en high, rr <= (g+1) mod NUM_REQ and buf_valid[g] clears unless reloaded per REQ-019; no grant -> rr holds.
REQ-026 Rollback squash: when rollback_en & en, every buffer whose rob_idx is younger than rollback_idx clears at the edge; incoming requests younger than rollback_idx are dropped (not captured) though req_ready is unchanged; older/equal entries are unaffected.
REQ-027 Simultaneous grant and squash of the same buffer cannot occur (REQ-021); simultaneous grant of one buffer and squash of others is legal.
REQ-028 Starvation bound: an eligible buffer is granted within NUM_REQ cycles of continuous en.
REQ-029 en low: no state change, complete_en=0, grant=0, req_ready=0.
REQ-030 Two buffers holding the same rob_idx is a requester protocol error; behaviour undefined, assertion flags it.

Reset
REQ-031 On reset: all buf_valid=0, buffer fields=0, rr=0; complete_en=0, grant=0, complete_ROB_idx=0, complete_T_idx=0; req_ready = en (all ones when en high).
REQ-032 Reset asserted mid-operation discards all buffered completions regardless of en or rollback_en; takes priority over all other updates.

Verification
REQ-033 Single: req_valid=0001, rob_idx0=3, T0=17 at edge t -> cycle t+1 complete_en=1, ROB_idx=3, T_idx=17, grant=0001, rr=1.
REQ-034 Contention: all four buffers loaded (idx 4,5,6,7), rr=0, no new requests -> grants 0001,0010,0100,1000 on four consecutive cycles; fifth cycle complete_en=0.
REQ-035 Back-to-back: requester 2 valid every cycle, others idle -> complete_en every cycle after first, req_ready[2] stays 1, no bubble.
REQ-036 Rollback with wrap: head=30, buffers idx 31,1,2,0 (requesters 0..3), rollback_idx=1 -> buffers with idx 2 cleared, 31/1/0 kept; grant that cycle never shows idx 2.
REQ-037 en=0 for 3 cycles with two buffers loaded -> complete_en=0, rr and buffers unchanged; en=1 resumes grants from saved rr.
REQ-038 Reset during rollback with all buffers full -> next cycle all buffers empty, rr=0, complete_en=0.
